puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
//  Sequencer for one arbiter-PUF chain of singleRound_puf switch stages.
//  - Takes a challenge and drives the stage select lines.
//  - Fires the race by raising both chain inputs.
//  - Waits for the delay paths to settle, then samples the arbiter.
//  - Majority-votes N_EVAL races per response bit and returns an RESP_W-bit response.
//  Sits between the host request interface and the PUF delay chain.
// PARAMETERS
//  N_STAGES    8   challenge width = number of switch stages
//  RESP_W      4   response bits per request; 1..N_STAGES
//  N_EVAL      3   races per response bit; must be odd and >=1
//  SETTLE_CYC  15  clock cycles allowed for chain propagation; >=1, matches stage DELAY
// PORTS
//  clk           in   1         single clock; all state updates on rising edge
//  rst_n         in   1         synchronous reset, active-low
//  req_valid     in   1         challenge request valid
//  req_ready     out  1         controller idle, can accept a request
//  req_challenge in   N_STAGES  base challenge
//  puf_challenge out  N_STAGES  stage sel bus driven to the chain
//  puf_launch    out  1         drives both chain inputs (a1/b1); 0 = relax, 1 = race
//  puf_arb_in    in   1         arbiter output; asynchronous to clk
//  rsp_valid     out  1         response valid
//  rsp_ready     in   1         consumer accepts response
//  rsp_data      out  RESP_W    majority-voted response
//  rsp_stable    out  1         1 = every vote unanimous
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; all outputs 0 except req_ready=1. Counters and vote registers cleared.
//  - Reset mid-operation aborts immediately. The partial response is discarded and no rsp_valid is issued.
//  - req_ready = (state==IDLE), combinational. Accept on req_valid&&req_ready: latch req_challenge, bit=0, eval=0.
//  - FSM IDLE -> SETUP -> LAUNCH -> (SETUP | DONE) -> IDLE.
//  - SETUP: puf_launch=0, puf_challenge=rotl(chal,bit). Lasts SETTLE_CYC cycles; this includes the relax time after the previous race.
//  - LAUNCH: puf_launch=1 for SETTLE_CYC+2 cycles. The +2 covers the 2-flop synchronizer on puf_arb_in.
//    On the last LAUNCH cycle the synchronized arbiter value is added to ones_cnt.
//  - After LAUNCH: eval++.
//    - If eval==N_EVAL: rsp_data[bit] <= (ones_cnt > N_EVAL/2), and stable &= (ones_cnt==0 || ones_cnt==N_EVAL). Then clear ones_cnt and eval and do bit++.
//    - If bit==RESP_W: go to DONE, else go to SETUP.
//  - Cycles per race: 2*SETTLE_CYC+2. rsp_valid rises exactly L = RESP_W*N_EVAL*(2*SETTLE_CYC+2)+1 edges after the accept edge.
//  - DONE: rsp_valid=1; rsp_data and rsp_stable are held stable while rsp_ready=0.
//    On rsp_valid&&rsp_ready go to IDLE; rsp_valid falls next cycle.
//  - req_valid is ignored outside IDLE. A request arriving in the same cycle as the response handshake is taken on the following cycle, once IDLE.
//  - puf_launch is 0 in IDLE and DONE. puf_challenge holds its last value until the next accept; it is 0 after reset.
//  - Rotation is left by bit index within N_STAGES bits, so bit 0 uses the unrotated challenge.
//  - Widths: ones_cnt is $clog2(N_EVAL+1) bits. Cycle counter is $clog2(SETTLE_CYC+3) bits and reloads on every state entry.
// STRUCTURE
//  - Package puf_pkg: FSM state encodings (IDLE/SETUP/LAUNCH/DONE) and the localparam helper for cycles per race.
//  - Sub-module puf_sync2 (2-flop synchronizer, reset to 0) on puf_arb_in.
//  - FSM, counters, vote logic and rotation stay in this module.
//  - Elaboration checks: N_EVAL odd, RESP_W<=N_STAGES, SETTLE_CYC>=1.
// TESTING (N_STAGES=8, RESP_W=4, N_EVAL=3, SETTLE_CYC=3 -> L=97)
//  1 Reset, hold rst_n=0 3 cycles -> req_ready=1, rsp_valid=0, puf_launch=0, puf_challenge=8'h00.
//  2 puf_arb_in tied 1, req 8'hA5 -> puf_challenge steps A5,4B,96,2D.
//    rsp_valid at accept+97; rsp_data=4'hF, rsp_stable=1.
//  3 Model: arb=1 except race 2 of bit 2 returns 0 -> rsp_data=4'hF, rsp_stable=0.
//    Arb=0 on 2 of 3 races of bit 1 -> rsp_data=4'hD.
//  4 Hold rsp_ready=0 for 10 cycles after rsp_valid -> data held, req_ready=0, req_valid pulses ignored.
//    Release -> IDLE next cycle.
//  5 Assert rst_n=0 at accept+40 -> next edge puf_launch=0, req_ready=1, no rsp_valid within 200 cycles.
//    New request then completes normally.
//  6 Pulse timing -> puf_launch high exactly 5 cycles, low 3 cycles between races, 12 pulses per request.
//    Back-to-back requests complete at L+1 spacing (97 from accept, +1 IDLE).

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation controller.
package puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_DONE   = 2'd3
    } puf_state_t;

    // One race = relax/setup window plus launch window (settle + 2 sync stages).
    function automatic int race_cycles(input int settle_cyc);
        return 2 * settle_cyc + 2;
    endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into the clk domain.
module puf_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the input; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer for one arbiter-PUF chain: applies rotated challenges, fires races,
// samples the arbiter after settling and majority-votes N_EVAL races per bit.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int N_STAGES   = 8,
    parameter int RESP_W     = 4,
    parameter int N_EVAL     = 3,
    parameter int SETTLE_CYC = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [N_STAGES-1:0] req_challenge,
    output logic [N_STAGES-1:0] puf_challenge,
    output logic                puf_launch,
    input  logic                puf_arb_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESP_W-1:0]   rsp_data,
    output logic                rsp_stable
);

    localparam int ONES_W = $clog2(N_EVAL + 1);
    localparam int EVAL_W = $clog2(N_EVAL + 1);
    localparam int BIT_W  = $clog2(RESP_W + 1);
    localparam int CNT_W  = $clog2(SETTLE_CYC + 3);

    localparam logic [CNT_W-1:0]  SETUP_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  LAUNCH_LOAD = CNT_W'(SETTLE_CYC + 1);
    localparam logic [ONES_W-1:0] HALF_VOTES  = ONES_W'(N_EVAL / 2);
    localparam logic [ONES_W-1:0] ALL_VOTES   = ONES_W'(N_EVAL);
    localparam logic [EVAL_W-1:0] LAST_EVAL   = EVAL_W'(N_EVAL - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(RESP_W - 1);

    if (N_EVAL < 1 || (N_EVAL % 2) == 0) begin : g_bad_n_eval
        $error("puf_eval_ctrl: N_EVAL must be odd and >= 1");
    end
    if (RESP_W < 1 || RESP_W > N_STAGES) begin : g_bad_resp_w
        $error("puf_eval_ctrl: RESP_W must be in 1..N_STAGES");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("puf_eval_ctrl: SETTLE_CYC must be >= 1");
    end

    puf_state_t          state;
    puf_state_t          next_state;
    logic [CNT_W-1:0]    cyc_cnt;
    logic [N_STAGES-1:0] chal_q;
    logic [BIT_W-1:0]    bit_idx;
    logic [EVAL_W-1:0]   eval_idx;
    logic [ONES_W-1:0]   ones_cnt;
    logic [ONES_W-1:0]   ones_total;
    logic                arb_sync;
    logic                race_end;
    logic                last_eval;
    logic                last_bit;
    logic                vote;
    logic                unanimous;
    logic                accept;

    function automatic logic [N_STAGES-1:0] rotl(input logic [N_STAGES-1:0] v,
                                                 input int unsigned k);
        logic [2*N_STAGES-1:0] dbl;
        dbl = {v, v} << k;
        return dbl[2*N_STAGES-1:N_STAGES];
    endfunction

    puf_sync2 u_arb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (puf_arb_in),
        .q     (arb_sync)
    );

    assign accept     = (state == ST_IDLE) && req_valid;
    assign race_end   = (state == ST_LAUNCH) && (cyc_cnt == '0);
    assign last_eval  = (eval_idx == LAST_EVAL);
    assign last_bit   = (bit_idx == LAST_BIT);
    assign ones_total = ones_cnt + ONES_W'(arb_sync);
    assign vote       = (ones_total > HALF_VOTES);
    assign unanimous  = (ones_total == '0) || (ones_total == ALL_VOTES);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived handshake/launch outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        puf_launch = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (cyc_cnt == '0) next_state = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                puf_launch = 1'b1;
                if (cyc_cnt == '0) next_state = (last_eval && last_bit) ? ST_DONE : ST_SETUP;
            end
            ST_DONE: begin
                if (rsp_valid && rsp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Phase timer, reloaded whenever the FSM enters a new state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (next_state != state) begin
            case (next_state)
                ST_SETUP:  cyc_cnt <= SETUP_LOAD;
                ST_LAUNCH: cyc_cnt <= LAUNCH_LOAD;
                default:   cyc_cnt <= '0;
            endcase
        end else if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - CNT_W'(1);
        end
    end

    // Challenge latch, race/bit counters and per-bit majority vote.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chal_q        <= '0;
            puf_challenge <= '0;
            bit_idx       <= '0;
            eval_idx      <= '0;
            ones_cnt      <= '0;
            rsp_data      <= '0;
            rsp_stable    <= 1'b0;
        end else if (accept) begin
            chal_q        <= req_challenge;
            puf_challenge <= req_challenge;
            bit_idx       <= '0;
            eval_idx      <= '0;
            ones_cnt      <= '0;
            rsp_data      <= '0;
            rsp_stable    <= 1'b1;
        end else if (race_end) begin
            if (last_eval) begin
                for (int i = 0; i < RESP_W; i++) begin
                    if (bit_idx == BIT_W'(i)) rsp_data[i] <= vote;
                end
                rsp_stable <= rsp_stable & unanimous;
                ones_cnt   <= '0;
                eval_idx   <= '0;
                bit_idx    <= bit_idx + BIT_W'(1);
                if (!last_bit) puf_challenge <= rotl(chal_q, int'(bit_idx) + 1);
            end else begin
                ones_cnt <= ones_total;
                eval_idx <= eval_idx + EVAL_W'(1);
            end
        end
    end

    // Response valid is presented one cycle after DONE entry and drops on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= (state == ST_DONE) && !(rsp_valid && rsp_ready);
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed self-checking bench for puf_eval_ctrl with a short settle time.
module tb_puf_eval_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_challenge;
    logic [7:0] puf_challenge;
    logic       puf_launch;
    logic       puf_arb_in;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_stable;

    int         check_cnt = 0;
    int         pass_cnt  = 0;

    logic [11:0] arb_pat;
    logic [7:0]  chal_log [12];
    logic        prev_launch;
    int          race, pulse_cnt, hi_len, lo_len;
    int          hi_min, hi_max, lo_min, lo_max;

    puf_eval_ctrl #(
        .N_STAGES   (8),
        .RESP_W     (4),
        .N_EVAL     (3),
        .SETTLE_CYC (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .puf_challenge (puf_challenge),
        .puf_launch    (puf_launch),
        .puf_arb_in    (puf_arb_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_stable    (rsp_stable)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Arbiter model and launch-pulse monitor: each race gets the next bit of
    // arb_pat, and pulse widths/gaps plus the applied challenge are logged.
    initial begin
        puf_arb_in  = 1'b0;
        prev_launch = 1'b0;
        race = 0; pulse_cnt = 0; hi_len = 0; lo_len = 0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || req_ready) begin
                race = 0; pulse_cnt = 0; hi_len = 0; lo_len = 0;
                hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
            end else if (puf_launch && !prev_launch) begin
                if (pulse_cnt > 0) begin
                    if (lo_len < lo_min) lo_min = lo_len;
                    if (lo_len > lo_max) lo_max = lo_len;
                end
                if (race < 12) begin
                    chal_log[race] = puf_challenge;
                    puf_arb_in     = arb_pat[race];
                end
                race++;
                pulse_cnt++;
                hi_len = 1;
            end else if (puf_launch) begin
                hi_len++;
            end else if (prev_launch) begin
                if (hi_len < hi_min) hi_min = hi_len;
                if (hi_len > hi_max) hi_max = hi_len;
                lo_len = 1;
            end else begin
                lo_len++;
            end
            prev_launch = puf_launch;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic waitResponse(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] chal, input logic [11:0] pat,
                                 output int lat);
        arb_pat = pat;
        @(negedge clk);
        req_challenge = chal;
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waitResponse(lat);
    endtask

    task automatic checkHandshake(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_low"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_ready_high"}, 32'(req_ready), 32'd1);
    endtask

    task automatic checkPulses(input string tag);
        checkOutput({tag, "_pulses"}, 32'(pulse_cnt), 32'd12);
        checkOutput({tag, "_hi_min"}, 32'(hi_min), 32'd5);
        checkOutput({tag, "_hi_max"}, 32'(hi_max), 32'd5);
        checkOutput({tag, "_lo_min"}, 32'(lo_min), 32'd3);
        checkOutput({tag, "_lo_max"}, 32'(lo_max), 32'd3);
    endtask

    // Directed scenario sequence.
    initial begin
        logic [7:0] exp_chal [4];
        int lat;
        int stray;

        exp_chal[0] = 8'hA5; exp_chal[1] = 8'h4B; exp_chal[2] = 8'h96; exp_chal[3] = 8'h2D;
        rst_n = 1'b0; req_valid = 1'b0; req_challenge = 8'h00; rsp_ready = 1'b1;
        arb_pat = 12'hFFF;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_launch", 32'(puf_launch), 32'd0);
        checkOutput("rst_challenge", 32'(puf_challenge), 32'h00);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'h0);
        checkOutput("rst_rsp_stable", 32'(rsp_stable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones arbiter: rotation sequence, latency, pulse shape.
        applyStimulus(8'hA5, 12'hFFF, lat);
        checkOutput("t2_latency", 32'(lat), 32'd97);
        checkOutput("t2_data", 32'(rsp_data), 32'hF);
        checkOutput("t2_stable", 32'(rsp_stable), 32'd1);
        for (int r = 0; r < 12; r++) checkOutput("t2_chal_step", 32'(chal_log[r]), 32'(exp_chal[r / 3]));
        checkPulses("t2");
        checkHandshake("t2_hs");
        checkOutput("t2_chal_hold", 32'(puf_challenge), 32'h2D);

        // One dissenting race on bit 2: majority still 1, not unanimous.
        applyStimulus(8'h5A, 12'hF7F, lat);
        checkOutput("t3a_latency", 32'(lat), 32'd97);
        checkOutput("t3a_data", 32'(rsp_data), 32'hF);
        checkOutput("t3a_stable", 32'(rsp_stable), 32'd0);
        checkHandshake("t3a_hs");

        // Two zero races on bit 1: bit 1 votes 0.
        applyStimulus(8'h5A, 12'hFE7, lat);
        checkOutput("t3b_data", 32'(rsp_data), 32'hD);
        checkOutput("t3b_stable", 32'(rsp_stable), 32'd0);
        checkHandshake("t3b_hs");

        // All-zero arbiter: response 0 and unanimous.
        applyStimulus(8'h11, 12'h000, lat);
        checkOutput("t3c_data", 32'(rsp_data), 32'h0);
        checkOutput("t3c_stable", 32'(rsp_stable), 32'd1);
        checkHandshake("t3c_hs");

        // Consumer stalls 10 cycles; request pulses must be ignored.
        rsp_ready = 1'b0;
        applyStimulus(8'h81, 12'h1F8, lat);
        checkOutput("t4_latency", 32'(lat), 32'd97);
        checkOutput("t4_data", 32'(rsp_data), 32'h6);
        checkOutput("t4_stable", 32'(rsp_stable), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid     = (i % 2 == 0);
            req_challenge = 8'h3C;
            @(posedge clk);
            #1;
            checkOutput("t4_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("t4_hold_data", 32'(rsp_data), 32'h6);
            checkOutput("t4_hold_stable", 32'(rsp_stable), 32'd1);
            checkOutput("t4_hold_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checkHandshake("t4_hs");
        @(posedge clk);
        #1;
        checkOutput("t4_idle_ready", 32'(req_ready), 32'd1);
        checkOutput("t4_chal_kept", 32'(puf_challenge), 32'h0C);

        // Reset in the middle of a launch aborts the request.
        arb_pat = 12'hFFF;
        @(negedge clk);
        req_challenge = 8'h33;
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        checkOutput("t5_pre_launch", 32'(puf_launch), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_launch", 32'(puf_launch), 32'd0);
        checkOutput("t5_ready", 32'(req_ready), 32'd1);
        checkOutput("t5_challenge", 32'(puf_challenge), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (rsp_valid) stray++;
        end
        checkOutput("t5_no_rsp", 32'(stray), 32'd0);
        applyStimulus(8'hC3, 12'hFFF, lat);
        checkOutput("t5_after_latency", 32'(lat), 32'd97);
        checkOutput("t5_after_data", 32'(rsp_data), 32'hF);
        checkHandshake("t5_hs");

        // Back-to-back: a request held during the handshake is taken once IDLE.
        applyStimulus(8'h0F, 12'h000, lat);
        checkOutput("t6_first_data", 32'(rsp_data), 32'h0);
        req_challenge = 8'hF0;
        req_valid     = 1'b1;
        arb_pat       = 12'hFFF;
        @(posedge clk);
        #1;
        checkOutput("t6_hs_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t6_hs_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("t6_accepted", 32'(req_ready), 32'd0);
        checkOutput("t6_chal", 32'(puf_challenge), 32'hF0);
        waitResponse(lat);
        checkOutput("t6_latency", 32'(lat), 32'd97);
        checkOutput("t6_data", 32'(rsp_data), 32'hF);
        checkOutput("t6_stable", 32'(rsp_stable), 32'd1);
        checkPulses("t6");
        checkHandshake("t6_hs2");

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
